// File: rtl/dma_dump_if.sv
// Bundle of the processor request, local-memory read and shared-memory write signals.
// Pure wiring: no storage, no latency of its own.
// Backpressure is carried by SHM_READY; ma_request is a level held until ma_answer.
interface dma_dump_if;
  // Processor request side
  logic        ma_request;
  logic [15:0] MA_WHAT;
  logic [15:0] MA_WHERE;
  logic [15:0] MA_COUNT;
  logic        ma_answer;
  logic [15:0] MA_ANSWER;
  logic        busy;

  // Local memory read port (synchronous read, data one clk after address)
  logic [15:0] MEMORY_ADDR;
  logic [15:0] MEMORY_OUT;

  // Shared memory write port
  logic [15:0] SHM_ADDR;
  logic [15:0] SHM_DATA;
  logic        SHM_WE;
  logic        SHM_READY;

  // DMA engine view
  modport slave (
    input  ma_request, MA_WHAT, MA_WHERE, MA_COUNT, MEMORY_OUT, SHM_READY,
    output ma_answer, MA_ANSWER, busy, MEMORY_ADDR, SHM_ADDR, SHM_DATA, SHM_WE
  );

  // Processor / memory / test environment view
  modport master (
    output ma_request, MA_WHAT, MA_WHERE, MA_COUNT, MEMORY_OUT, SHM_READY,
    input  ma_answer, MA_ANSWER, busy, MEMORY_ADDR, SHM_ADDR, SHM_DATA, SHM_WE
  );
endinterface

// File: rtl/dma_dump.sv
// Copies MA_COUNT words from processor local memory to shared memory, one word at a time.
// Latency: 3 cycles per word with SHM_READY high; N words take 3N+1 cycles from accept to ma_answer.
// Backpressure: a pending shared-memory write is held indefinitely until SHM_READY; request inputs ignored while busy.
module dma_dump #(
  parameter int LOCAL_AW = 10
) (
  input logic       clk,
  input logic       clr,
  dma_dump_if.slave bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_READ  = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_HOLD  = 3'd5;

  // Local addresses wrap through truncation to LOCAL_AW bits; upper bits read as zero.
  localparam logic [15:0] LOCAL_MASK = 16'((32'd1 << LOCAL_AW) - 32'd1);

  logic [2:0]  r_state;
  logic [2:0]  w_next_state;
  logic        r_busy;

  logic [15:0] r_src;
  logic [15:0] r_dst;
  logic [15:0] r_rem;
  logic [15:0] r_cnt;

  logic [15:0] r_mem_addr;
  logic [15:0] r_shm_addr;
  logic [15:0] r_shm_data;
  logic        r_shm_we;
  logic        r_answer_pls;
  logic [15:0] r_answer_cnt;

  logic        w_accept;
  logic        w_wr_ack;
  logic [15:0] w_src_inc;
  logic [15:0] w_dst_inc;
  logic [15:0] w_rem_dec;

  assign w_accept  = (r_state == ST_IDLE) && bus.ma_request;
  assign w_wr_ack  = (r_state == ST_WRITE) && bus.SHM_READY;
  assign w_src_inc = r_src + 16'd1;
  assign w_dst_inc = r_dst + 16'd1;
  assign w_rem_dec = r_rem - 16'd1;

  // Next-state selection for the transfer sequencer
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (bus.ma_request) w_next_state = (bus.MA_COUNT == 16'd0) ? ST_DONE : ST_READ;
      ST_READ:  w_next_state = ST_WAIT;
      ST_WAIT:  w_next_state = ST_WRITE;
      ST_WRITE: if (bus.SHM_READY) w_next_state = (w_rem_dec == 16'd0) ? ST_DONE : ST_READ;
      ST_DONE:  w_next_state = ST_HOLD;
      ST_HOLD:  if (!bus.ma_request) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // State register; busy is registered alongside so it tracks the state exactly
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state != ST_IDLE);
    end
  end

  // Transfer bookkeeping: pointers, remaining words and words-written counter
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_src <= 16'd0;
      r_dst <= 16'd0;
      r_rem <= 16'd0;
      r_cnt <= 16'd0;
    end else if (w_accept) begin
      r_src <= bus.MA_WHAT;
      r_dst <= bus.MA_WHERE;
      r_rem <= bus.MA_COUNT;
      r_cnt <= 16'd0;
    end else if (w_wr_ack) begin
      r_src <= w_src_inc;
      r_dst <= w_dst_inc;
      r_rem <= w_rem_dec;
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Read address is loaded on entry to READ so the synchronous memory samples it at the READ edge
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_mem_addr <= 16'd0;
    end else if (w_accept) begin
      r_mem_addr <= bus.MA_WHAT & LOCAL_MASK;
    end else if (w_wr_ack) begin
      r_mem_addr <= w_src_inc & LOCAL_MASK;
    end
  end

  // Shared-memory write: capture read data in WAIT, hold until the accepting edge
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_shm_addr <= 16'd0;
      r_shm_data <= 16'd0;
      r_shm_we   <= 1'b0;
    end else if (r_state == ST_WAIT) begin
      r_shm_addr <= r_dst;
      r_shm_data <= bus.MEMORY_OUT;
      r_shm_we   <= 1'b1;
    end else if (w_wr_ack) begin
      r_shm_we   <= 1'b0;
    end
  end

  // Completion: one-cycle pulse and word count, count held until the next completion
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_answer_pls <= 1'b0;
      r_answer_cnt <= 16'd0;
    end else begin
      r_answer_pls <= (r_state == ST_DONE);
      if (r_state == ST_DONE) begin
        r_answer_cnt <= r_cnt;
      end
    end
  end

  assign bus.MEMORY_ADDR = r_mem_addr;
  assign bus.SHM_ADDR    = r_shm_addr;
  assign bus.SHM_DATA    = r_shm_data;
  assign bus.SHM_WE      = r_shm_we;
  assign bus.ma_answer   = r_answer_pls;
  assign bus.MA_ANSWER   = r_answer_cnt;
  assign bus.busy        = r_busy;

endmodule

// File: doc/dma_dump.md
DMA_DUMP -- requirements
Module: dma_dump

Interface
REQ-001 SHALL have parameter LOCAL_AW, default 10, meaning the significant local-memory address bits.
REQ-002 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port clr  input  1  meaning the reset, asynchronous and active-low.
REQ-004 SHALL have port ma_request  input  1  meaning the processor dump request, level, held until ma_answer.
REQ-005 SHALL have port MA_WHAT  input  16  meaning the source word address in processor local memory.
REQ-006 SHALL have port MA_WHERE  input  16  meaning the destination word address in shared memory.
REQ-007 SHALL have port MA_COUNT  input  16  meaning the number of words to copy.
REQ-008 SHALL have port MEMORY_ADDR  output  16  meaning the local-memory read address; bits above LOCAL_AW are driven 0.
REQ-009 SHALL have port MEMORY_OUT  input  16  meaning local read data, valid one clk after MEMORY_ADDR is presented.
REQ-010 SHALL have port SHM_ADDR  output  16  meaning the shared-memory write address.
REQ-011 SHALL have port SHM_DATA  output  16  meaning the shared-memory write data.
REQ-012 SHALL have port SHM_WE  output  1  meaning a write is pending; held until accepted.
REQ-013 SHALL have port SHM_READY  input  1  meaning shared memory accepts the pending write at this edge.
REQ-014 SHALL have port ma_answer  output  1  meaning a one-cycle completion pulse.
REQ-015 SHALL have port MA_ANSWER  output  16  meaning the count of words written by the last transfer.
REQ-016 SHALL have port busy  output  1  meaning the FSM is not in IDLE.

Function
REQ-017 SHALL implement the states IDLE, READ, WAIT, WRITE, DONE and HOLD; all outputs are registered.
REQ-018 IDLE: on an edge with ma_request=1, SHALL latch src=MA_WHAT, dst=MA_WHERE, rem=MA_COUNT, clear the word counter, and go to READ; if MA_COUNT=0 it SHALL go to DONE instead.
REQ-019 READ: SHALL drive MEMORY_ADDR = src[LOCAL_AW-1:0] zero-extended, then go to WAIT.
REQ-020 WAIT: SHALL capture MEMORY_OUT into SHM_DATA, set SHM_ADDR=dst and SHM_WE=1, then go to WRITE.
REQ-021 WRITE: SHALL hold SHM_WE, SHM_ADDR and SHM_DATA stable while SHM_READY=0, with no timeout.
REQ-022 WRITE: on an edge with SHM_READY=1, SHALL drop SHM_WE, increment the word counter, src and dst, and decrement rem.
REQ-023 WRITE: after that accepting edge, SHALL go to DONE if the new rem=0, else to READ.
REQ-024 Throughput SHALL be 3 cycles per word when SHM_READY is held at 1; an N-word transfer takes 3N+1 cycles from accept to the ma_answer pulse.
REQ-025 src and dst SHALL increment modulo 2^16; local addressing wraps modulo 2^LOCAL_AW through the bit truncation.
REQ-026 DONE: SHALL assert ma_answer for exactly one cycle, load MA_ANSWER from the word counter, and go to HOLD.
REQ-027 HOLD: SHALL stay until ma_request=0, then go to IDLE, so a held request never re-triggers.
REQ-028 MA_WHAT, MA_WHERE and MA_COUNT SHALL be ignored outside IDLE; changes during a transfer have no effect.
REQ-029 MA_ANSWER SHALL hold its value until the next DONE.
REQ-030 busy SHALL be 1 in every state except IDLE.

Reset
REQ-031 clr=0 SHALL immediately force IDLE and zero every output (MEMORY_ADDR, SHM_ADDR, SHM_DATA, SHM_WE, ma_answer, MA_ANSWER, busy) and every internal register, asynchronously to clk.
REQ-032 Reset mid-transfer SHALL abandon the transfer with no ma_answer pulse; a write pending on that edge is withdrawn.
REQ-033 After clr returns to 1, a ma_request still high SHALL start a new transfer on the first edge.

Verification
REQ-034 Scenario: local[0x010..0x012]={0xAAAA,0xBBBB,0xCCCC}, WHAT=0x0010, WHERE=0x2000, COUNT=3, SHM_READY=1 -> writes 0x2000=0xAAAA, 0x2001=0xBBBB, 0x2002=0xCCCC; ma_answer pulses 10 cycles after accept; MA_ANSWER=3.
REQ-035 Scenario: COUNT=0 -> no SHM_WE; ma_answer pulses on the second edge after request; MA_ANSWER=0.
REQ-036 Scenario: SHM_READY=0 for 5 cycles on word 2 -> SHM_WE, SHM_ADDR and SHM_DATA stay stable; the total is 5 cycles longer; data is still correct.
REQ-037 Scenario: WHAT=0x03FF, WHERE=0xFFFF, COUNT=2 -> reads at 0x03FF then 0x0000; writes at 0xFFFF then 0x0000.
REQ-038 Scenario: clr pulsed low during WRITE of word 2 of 4 -> all outputs 0 immediately, no ma_answer; with ma_request still 1, a fresh 4-word transfer restarts from the original WHAT.
REQ-039 Scenario: ma_request held high 6 cycles past ma_answer -> exactly one transfer, FSM stays in HOLD until the request drops, busy=1 throughout.
